// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================
// pc_gen_pkg : shared widths, reset vector and PC-stage states
// Rev 1.0
// ============================================================
package pc_gen_pkg;

  localparam int ADDR_BUS_WIDTH = 32;
  localparam int GHR_BUS = 5;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc0_0000;
  localparam int DEFAULT_INST_BYTES = 4;

  typedef enum logic [0:0] {
    PC_STATE_RUN  = 1'b0,
    PC_STATE_HOLD = 1'b1
  } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================
// pc_gen_if : redirect / BTB / PHT inputs and PC->IF outputs
// Rev 1.0
// ============================================================
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS_WIDTH,
  parameter int GHR_WIDTH  = GHR_BUS
);
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [GHR_WIDTH-1:0]  redirect_ghr;
  logic                  btb_hit;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic [1:0]            pht_counter;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  is_branch_taken_out;
  logic [GHR_WIDTH-1:0]  pht_index_out;
  logic                  redirect_pending_out;

  modport master (
    input  stall, redirect_valid, redirect_pc, redirect_ghr,
    input  btb_hit, btb_target, pht_counter,
    output pc_out, is_branch_taken_out, pht_index_out, redirect_pending_out
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, redirect_ghr,
    output btb_hit, btb_target, pht_counter,
    input  pc_out, is_branch_taken_out, pht_index_out, redirect_pending_out
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen_redirect_latch.sv
`default_nettype none
// ============================================================
// pc_redirect_latch : holds a redirect that arrived during a stall
// Rev 1.0
// ============================================================
module pc_redirect_latch #(
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_WIDTH  = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  load,
  input  wire logic                  clear,
  input  wire logic [ADDR_WIDTH-1:0] load_pc,
  input  wire logic [GHR_WIDTH-1:0]  load_ghr,
  output logic                       valid,
  output logic [ADDR_WIDTH-1:0]      held_pc,
  output logic [GHR_WIDTH-1:0]       held_ghr
);

  // Load beats clear so the youngest redirect always survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      held_pc  <= '0;
      held_ghr <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      held_pc  <= load_pc;
      held_ghr <= load_ghr;
    end else if (clear) begin
      valid    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================
// pc_gen : next-fetch-address selection, speculative GHR, gshare index
// Rev 1.0
// ============================================================
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_BUS_WIDTH,
  parameter int                    GHR_WIDTH  = GHR_BUS,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                    INST_BYTES = DEFAULT_INST_BYTES
) (
  input wire logic  clk,
  input wire logic  rst,
  pc_gen_if.master  bus
);

  pc_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [GHR_WIDTH-1:0]  ghr, ghr_nxt;
  logic                  advance;
  logic                  predict_taken;
  logic                  redirect_active;
  logic [ADDR_WIDTH-1:0] sel_pc;
  logic [GHR_WIDTH-1:0]  sel_ghr;
  logic                  latch_valid;
  logic [ADDR_WIDTH-1:0] latch_pc;
  logic [GHR_WIDTH-1:0]  latch_ghr;

  assign advance       = ~bus.stall;
  assign predict_taken = bus.btb_hit & bus.pht_counter[1];

  pc_redirect_latch #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .GHR_WIDTH  (GHR_WIDTH)
  ) u_latch (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.stall & bus.redirect_valid),
    .clear    (advance),
    .load_pc  (bus.redirect_pc),
    .load_ghr (bus.redirect_ghr),
    .valid    (latch_valid),
    .held_pc  (latch_pc),
    .held_ghr (latch_ghr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PC_STATE_RUN;
      pc    <= RESET_PC;
      ghr   <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        pc  <= pc_nxt;
        ghr <= ghr_nxt;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    redirect_active = bus.redirect_valid;
    sel_pc          = bus.redirect_pc;
    sel_ghr         = bus.redirect_ghr;
    pc_nxt          = pc + ADDR_WIDTH'(INST_BYTES);
    ghr_nxt         = ghr;

    case (state)
      PC_STATE_RUN: begin
        if (bus.stall && bus.redirect_valid) state_nxt = PC_STATE_HOLD;
      end
      PC_STATE_HOLD: begin
        if (!bus.stall) state_nxt = PC_STATE_RUN;
        // A same-cycle redirect is younger than the latched one.
        if (!bus.redirect_valid && latch_valid) begin
          redirect_active = 1'b1;
          sel_pc          = latch_pc;
          sel_ghr         = latch_ghr;
        end
      end
      default: state_nxt = PC_STATE_RUN;
    endcase

    if (redirect_active) begin
      pc_nxt  = sel_pc;
      ghr_nxt = sel_ghr;
    end else begin
      if (predict_taken) pc_nxt = bus.btb_target;
      if (bus.btb_hit)   ghr_nxt = {ghr[GHR_WIDTH-2:0], predict_taken};
    end
  end

  assign bus.pc_out               = pc;
  assign bus.is_branch_taken_out  = predict_taken;
  assign bus.pht_index_out        = pc[GHR_WIDTH+1:2] ^ ghr;
  assign bus.redirect_pending_out = (state == PC_STATE_HOLD);

endmodule
`default_nettype wire
